// File: rtl/sobel_edge_post.sv
// -----------------------------------------------------------------------------
// sobel_edge_post
//
// Post-processing stage for the Sobel gradient magnitude stream.
//   - Drops the first IN_DELAY strobes after reset or frame_restart. These
//     samples are upstream pipeline fill.
//   - Tracks the (col,row) position of every accepted sample.
//   - Saturates the 32-bit unsigned magnitude to 8 bits.
//   - Forces to zero the pixels in the first two columns and the first two
//     rows, where the 3x3 window is incomplete.
//   - Optional: binarizes the value against a threshold, giving 0 or 255.
//     This is enabled by defining the macro SOBEL_BINARIZE_EN.
//
// Latency from an accepted strobe to pix_valid is 2 cycles. Throughput is
// one pixel per clock.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   en             pixel strobe; one sample per high cycle
//   frame_restart  synchronous restart into the fill state. It wins over en.
//   grad_in[31:0]  unsigned gradient magnitude
//   threshold[7:0] binarize threshold, sampled with each accepted pixel
//   pix_out[7:0]   edge-map pixel
//   pix_valid      one-cycle pulse per emitted pixel
//   sol / eol      start / end of line, qualified by pix_valid
//   frame_done     last pixel of the frame, qualified by pix_valid
// -----------------------------------------------------------------------------
module sobel_edge_post #(
  parameter int PIX_PER_LINE    = 695,
  parameter int LINES_PER_FRAME = 520,
  parameter int IN_DELAY        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_restart,
  input  logic [31:0] grad_in,
  input  logic [7:0]  threshold,
  output logic [7:0]  pix_out,
  output logic        pix_valid,
  output logic        sol,
  output logic        eol,
  output logic        frame_done
);

  localparam int CW = (PIX_PER_LINE > 1)    ? $clog2(PIX_PER_LINE)    : 1;
  localparam int RW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int FW = (IN_DELAY > 1)        ? $clog2(IN_DELAY)        : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(PIX_PER_LINE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(LINES_PER_FRAME - 1);
  // The counter never holds IN_DELAY itself. The strobe that would reach it
  // moves the FSM to RUN instead.
  localparam logic [FW-1:0] FILL_LAST = FW'((IN_DELAY > 0) ? IN_DELAY - 1 : 0);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // With no fill required, reset and restart both go straight to RUN.
  localparam state_t START_STATE = (IN_DELAY == 0) ? RUN : FILL;

  // ---------------------------------------------------------------------------
  // Position / fill FSM
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            accept;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = 1'b0;

    if (frame_restart) begin
      state_d = START_STATE;
      fill_d  = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (en) begin
      case (state_q)
        FILL: begin
          if (fill_q == FILL_LAST) begin
            state_d = RUN;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        RUN: begin
          accept = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            // Frames are back-to-back. Row wraps and the FSM stays in RUN.
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        default: state_d = START_STATE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: saturate, mask border, capture position flags (pre-increment)
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic [7:0]  s1_val_q, s1_val_d;
  logic        s1_sol_q, s1_sol_d;
  logic        s1_eol_q, s1_eol_d;
  logic        s1_fd_q, s1_fd_d;
  logic        border;
  logic [7:0]  sat;

`ifdef SOBEL_BINARIZE_EN
  logic        s1_mask_q, s1_mask_d;
  logic [7:0]  s1_thr_q, s1_thr_d;
`else
  logic        unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  always_comb begin
    sat        = (|grad_in[31:8]) ? 8'hFF : grad_in[7:0];
    border     = (32'(col_q) < 32'd2) || (32'(row_q) < 32'd2);
    s1_valid_d = accept;
    s1_val_d   = border ? 8'h00 : sat;
    s1_sol_d   = (col_q == '0);
    s1_eol_d   = (col_q == COL_LAST);
    s1_fd_d    = (col_q == COL_LAST) && (row_q == ROW_LAST);
`ifdef SOBEL_BINARIZE_EN
    s1_mask_d  = border;
    s1_thr_d   = threshold;
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage 2: optional binarize, drive outputs
  // ---------------------------------------------------------------------------
  logic [7:0]  pix_out_q, pix_out_d;
  logic        pix_valid_q, pix_valid_d;
  logic        sol_q, sol_d;
  logic        eol_q, eol_d;
  logic        frame_done_q, frame_done_d;

  always_comb begin
`ifdef SOBEL_BINARIZE_EN
    // The mask flag is carried separately. This keeps a border pixel at 0
    // even when threshold is 0, which would otherwise pass 0 >= 0.
    pix_out_d = (s1_valid_q && !s1_mask_q && (s1_val_q >= s1_thr_q)) ? 8'hFF : 8'h00;
`else
    pix_out_d = s1_valid_q ? s1_val_q : 8'h00;
`endif
    pix_valid_d  = s1_valid_q;
    sol_d        = s1_valid_q & s1_sol_q;
    eol_d        = s1_valid_q & s1_eol_q;
    frame_done_d = s1_valid_q & s1_fd_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= START_STATE;
      fill_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_val_q     <= '0;
      s1_sol_q     <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_fd_q      <= 1'b0;
`ifdef SOBEL_BINARIZE_EN
      s1_mask_q    <= 1'b0;
      s1_thr_q     <= '0;
`endif
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_val_q     <= s1_val_d;
      s1_sol_q     <= s1_sol_d;
      s1_eol_q     <= s1_eol_d;
      s1_fd_q      <= s1_fd_d;
`ifdef SOBEL_BINARIZE_EN
      s1_mask_q    <= s1_mask_d;
      s1_thr_q     <= s1_thr_d;
`endif
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      sol_q        <= sol_d;
      eol_q        <= eol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign sol        = sol_q;
  assign eol        = eol_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_edge_post.sv
module tb_sobel_edge_post;

  localparam int PPL = 8;
  localparam int LPF = 4;
  localparam int IND = 2;
`ifdef SOBEL_BINARIZE_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        frame_restart;
  logic [31:0] grad_in;
  logic [7:0]  threshold;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        sol;
  logic        eol;
  logic        frame_done;

  sobel_edge_post #(
    .PIX_PER_LINE   (PPL),
    .LINES_PER_FRAME(LPF),
    .IN_DELAY       (IND)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .frame_restart(frame_restart),
    .grad_in      (grad_in),
    .threshold    (threshold),
    .pix_out      (pix_out),
    .pix_valid    (pix_valid),
    .sol          (sol),
    .eol          (eol),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] p;
    logic       s;
    logic       e;
    logic       f;
  } exp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  pipe0, pipe1;
  string tag0, tag1;
  int    col, row;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected pixel value, taken directly from the block's behaviour:
  // border is 0, otherwise saturate, then optionally binarize.
  function automatic logic [7:0] model_pix(input int c, input int r,
                                           input logic [31:0] g, input logic [7:0] t);
    logic [7:0] v;
    if (c < 2 || r < 2) return 8'd0;
    v = (g > 32'd255) ? 8'hFF : g[7:0];
    return BIN ? ((v >= t) ? 8'hFF : 8'h00) : v;
  endfunction

  // One clock. First check the outputs due from the strobe two steps back.
  // Then drive the new inputs and queue their expectation.
  task automatic step(input logic e, input logic fr, input logic [31:0] g,
                      input exp_t x, input string tag);
    @(posedge clk);
    #1;
    check_val({tag1, "/valid"}, 32'(pix_valid), 32'(pipe1.v));
    if (pipe1.v) check_val({tag1, "/pix"}, 32'(pix_out), 32'(pipe1.p));
    check_val({tag1, "/sol"}, 32'(sol), 32'(pipe1.s));
    check_val({tag1, "/eol"}, 32'(eol), 32'(pipe1.e));
    check_val({tag1, "/frame_done"}, 32'(frame_done), 32'(pipe1.f));
    $display("step %s: en=%0b restart=%0b grad=%0d | out valid=%0b pix=%0d sol=%0b eol=%0b fd=%0b",
             tag, e, fr, g, pix_valid, pix_out, sol, eol, frame_done);
    pipe1 = pipe0;
    tag1  = tag0;
    pipe0 = x;
    tag0  = tag;
    en            = e;
    frame_restart = fr;
    grad_in       = g;
  endtask

  task automatic nopx(input logic e, input logic fr, input logic [31:0] g, input string tag);
    exp_t x;
    x = '0;
    step(e, fr, g, x, tag);
  endtask

  task automatic px(input logic [31:0] g);
    exp_t x;
    x.v = 1'b1;
    x.p = model_pix(col, row, g, threshold);
    x.s = (col == 0);
    x.e = (col == PPL - 1);
    x.f = (col == PPL - 1) && (row == LPF - 1);
    step(1'b1, 1'b0, g, x, $sformatf("px(%0d,%0d)", col, row));
    if (col == PPL - 1) begin
      col = 0;
      row = (row == LPF - 1) ? 0 : row + 1;
    end else begin
      col = col + 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "/pix"}, 32'(pix_out), 32'd0);
    check_val({tag, "/valid"}, 32'(pix_valid), 32'd0);
    check_val({tag, "/sol"}, 32'(sol), 32'd0);
    check_val({tag, "/eol"}, 32'(eol), 32'd0);
    check_val({tag, "/frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; frame_restart = 1'b0; grad_in = '0; threshold = 8'd30;
    pipe0 = '0; pipe1 = '0; tag0 = "idle"; tag1 = "idle";
    col = 0; row = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill: two discarded strobes, then the first pixel at (0,0)
    nopx(1'b1, 1'b0, 32'd100, "fill0");
    nopx(1'b1, 1'b0, 32'd100, "fill1");
    px(32'd100);

    // Rest of frame 0 at 40, with one idle cycle in the middle
    for (int i = 1; i < PPL * LPF; i++) begin
      if (i == 10) nopx(1'b0, 1'b0, 32'd999, "idle_mid");
      px(32'd40);
    end

    // Frame 1 continues with no re-fill: rows 0-1 plus two border columns
    for (int i = 0; i < 2 * PPL + 2; i++) px(32'd40);
    // Saturation at interior positions (2,2) and (3,2)
    px(32'd300);
    px(32'h8000_0000);
    // Threshold cases at (4,2) (5,2) (6,2), then (7,2), then border (0,3)
    threshold = 8'd50;
    px(32'd49);
    px(32'd50);
    px(32'd200);
    px(32'd49);
    px(32'd200);

    // Restart coincident with en at (1,3): sample dropped, refill
    nopx(1'b1, 1'b1, 32'd77, "restart");
    col = 0; row = 0;
    nopx(1'b1, 1'b0, 32'd77, "refill0");
    nopx(1'b1, 1'b0, 32'd77, "refill1");
    px(32'd123);
    px(32'd40);
    px(32'd40);

    // Reset mid-frame while a pixel is in flight
    @(posedge clk);
    #1;
    en = 1'b0;
    check_val("pre_rst/valid", 32'(pix_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pipe0 = '0; pipe1 = '0; tag0 = "post_rst"; tag1 = "post_rst";
    col = 0; row = 0;
    nopx(1'b0, 1'b0, 32'd0, "post_rst_idle0");
    nopx(1'b0, 1'b0, 32'd0, "post_rst_idle1");
    nopx(1'b1, 1'b0, 32'd90, "post_rst_fill0");
    nopx(1'b1, 1'b0, 32'd90, "post_rst_fill1");
    px(32'd90);
    px(32'd90);
    nopx(1'b0, 1'b0, 32'd0, "drain0");
    nopx(1'b0, 1'b0, 32'd0, "drain1");
    nopx(1'b0, 1'b0, 32'd0, "drain2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
